// File: rtl/sha256_compress.sv
// sha256_compress: single-block SHA-256 compression engine holding the chaining value H (optional SHA256_UNROLL2_EN: two rounds per cycle)
module sha256_compress (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         init_message,
    input  logic         init_iv,
    input  logic [511:0] data_in,
    output logic [255:0] data_out,
    output logic         data_out_valid,
    output logic         done,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

    localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    localparam logic [0:63][31:0] K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

`ifdef SHA256_UNROLL2_EN
    localparam logic [5:0] STEP = 6'd2;
    localparam logic [5:0] LAST = 6'd62;
`else
    localparam logic [5:0] STEP = 6'd1;
    localparam logic [5:0] LAST = 6'd63;
`endif

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] w_gen(input logic [31:0] wm16, input logic [31:0] wm15,
                                          input logic [31:0] wm7, input logic [31:0] wm2);
        return (rotr(wm2, 17) ^ rotr(wm2, 19) ^ (wm2 >> 10)) + wm7
             + (rotr(wm15, 7) ^ rotr(wm15, 18) ^ (wm15 >> 3)) + wm16;
    endfunction

    function automatic logic [255:0] sha_round(input logic [255:0] s, input logic [31:0] k, input logic [31:0] w);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        {a, b, c, d, e, f, g, h} = s;
        t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
        t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

    state_t             r_state, w_state_nx;
    logic [255:0]       r_hv, r_s, w_s_nx, w_hsum;
    logic [0:15][31:0]  r_w, w_w_nx;
    logic [5:0]         r_t;
    logic [31:0]        w_n0;
    logic               r_done, r_busy, r_valid;
`ifdef SHA256_UNROLL2_EN
    logic [255:0]       w_s_mid;
    logic [31:0]        w_n1;
`endif

    assign data_out       = r_hv;
    assign data_out_valid = r_valid;
    assign done           = r_done;
    assign busy           = r_busy;

    // Round datapath: next working variables, next schedule window, and the final H feed-forward sum
    always_comb begin
        w_n0 = w_gen(r_w[0], r_w[1], r_w[9], r_w[14]);
`ifdef SHA256_UNROLL2_EN
        w_n1    = w_gen(r_w[1], r_w[2], r_w[10], r_w[15]);
        w_s_mid = sha_round(r_s, K[r_t], r_w[0]);
        w_s_nx  = sha_round(w_s_mid, K[r_t + 6'd1], r_w[1]);
        w_w_nx  = {r_w[2:15], w_n0, w_n1};
`else
        w_s_nx  = sha_round(r_s, K[r_t], r_w[0]);
        w_w_nx  = {r_w[1:15], w_n0};
`endif
        w_hsum = '0;
        for (int i = 0; i < 8; i++) w_hsum[i*32 +: 32] = r_hv[i*32 +: 32] + r_s[i*32 +: 32];
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nx;
    end

    // FSM next-state: idle until start, rounds until the last one, then a single feed-forward cycle
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE:    w_state_nx = start ? ROUND : IDLE;
            ROUND:   w_state_nx = (r_t == LAST) ? FINAL : ROUND;
            FINAL:   w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    // Datapath registers: block capture, round iteration, H update and status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hv    <= IV;
            r_s     <= '0;
            r_w     <= '0;
            r_t     <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_w     <= data_in;
                        r_s     <= init_message ? IV : r_hv;
                        r_hv    <= init_message ? IV : r_hv;
                        r_t     <= '0;
                        r_busy  <= 1'b1;
                        r_valid <= 1'b0;
                    end else if (init_iv) begin
                        r_hv    <= data_in[511:256];
                        r_valid <= 1'b0;
                    end
                end
                ROUND: begin
                    r_s <= w_s_nx;
                    r_w <= w_w_nx;
                    r_t <= r_t + STEP;
                end
                FINAL: begin
                    r_hv    <= w_hsum;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sha256_compress.sv
// tb_sha256_compress: directed FIPS 180-4 vectors against sha256_compress, including latency, ignore-while-busy, IV load and mid-run reset
module tb_sha256_compress;
    logic         clk = 1'b0;
    logic         reset, start, init_message, init_iv;
    logic [511:0] data_in;
    logic [255:0] data_out;
    logic         data_out_valid, done, busy;

    int vectors = 0;
    int miscompares = 0;
    int lat, ndone;
    bit vbad;

`ifdef SHA256_UNROLL2_EN
    localparam int LAT = 34;
`else
    localparam int LAT = 66;
`endif

    localparam logic [255:0] IV   = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] ABC  = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] EMP  = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [255:0] MID  = 256'h85e655d6_417a1795_3363376a_624cde5c_76e09589_cac5f811_cc4b32c1_f20e533a;
    localparam logic [255:0] LONG = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    localparam logic [511:0] B_ABC = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] B_EMP = {32'h80000000, 480'h0};
    localparam logic [511:0] B_L1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] B_L2  = {480'h0, 32'h000001c0};

    sha256_compress dut (
        .clk(clk), .reset(reset), .start(start), .init_message(init_message), .init_iv(init_iv),
        .data_in(data_in), .data_out(data_out), .data_out_valid(data_out_valid), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // start pulse in cycle T; returns at the sampling point of T+1 with data_in scrambled
    task automatic launch(input logic [511:0] blk, input logic im);
        @(negedge clk);
        start = 1'b1;
        init_message = im;
        data_in = blk;
        @(negedge clk);
        start = 1'b0;
        init_message = 1'b0;
        data_in = {16{32'hdeadbeef}};
    endtask

    // n0 is the cycle offset from T at entry; n returns the offset at which done is seen
    task automatic wait_done(input int n0, output int n, output bit vb);
        n = n0;
        vb = 1'b0;
        while (!done && n < 200) begin
            if (data_out_valid) vb = 1'b1;
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        init_message = 1'b0;
        init_iv = 1'b0;
        data_in = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_data_out", data_out, IV);
        check("rst_valid", {255'h0, data_out_valid}, 256'h0);
        check("rst_done", {255'h0, done}, 256'h0);
        check("rst_busy", {255'h0, busy}, 256'h0);

        launch(B_ABC, 1'b1);
        check("abc_busy_t1", {255'h0, busy}, 256'h1);
        check("abc_valid_t1", {255'h0, data_out_valid}, 256'h0);
        wait_done(1, lat, vbad);
        check("abc_latency", 256'(lat), 256'(LAT));
        check("abc_digest", data_out, ABC);
        check("abc_valid_gap", {255'h0, vbad}, 256'h0);
        check("abc_busy_done", {255'h0, busy}, 256'h0);
        check("abc_valid_done", {255'h0, data_out_valid}, 256'h1);
        @(negedge clk);
        check("abc_done_pulse", {255'h0, done}, 256'h0);
        check("abc_valid_hold", {255'h0, data_out_valid}, 256'h1);

        launch(B_EMP, 1'b1);
        wait_done(1, lat, vbad);
        check("empty_digest", data_out, EMP);

        launch(B_L1, 1'b1);
        wait_done(1, lat, vbad);
        check("long_blk1", data_out, MID);
        launch(B_L2, 1'b0);
        wait_done(1, lat, vbad);
        check("long_blk2", data_out, LONG);

        @(negedge clk);
        init_iv = 1'b1;
        data_in = {MID, 256'h0123456789abcdef_0123456789abcdef_0123456789abcdef_0123456789abcdef};
        @(negedge clk);
        init_iv = 1'b0;
        data_in = '0;
        check("iv_load", data_out, MID);
        check("iv_valid_low", {255'h0, data_out_valid}, 256'h0);
        launch(B_L2, 1'b0);
        wait_done(1, lat, vbad);
        check("iv_valid_gap", {255'h0, vbad}, 256'h0);
        check("iv_digest", data_out, LONG);

        launch(B_ABC, 1'b1);
        repeat (9) @(negedge clk);
        start = 1'b1;
        init_iv = 1'b1;
        data_in = B_EMP;
        @(negedge clk);
        start = 1'b0;
        init_iv = 1'b0;
        wait_done(11, lat, vbad);
        check("busy_ign_latency", 256'(lat), 256'(LAT));
        check("busy_ign_digest", data_out, ABC);

        launch(B_ABC, 1'b1);
        repeat (29) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_busy", {255'h0, busy}, 256'h0);
        check("midrst_valid", {255'h0, data_out_valid}, 256'h0);
        check("midrst_data_out", data_out, IV);
        ndone = 0;
        repeat (80) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("midrst_no_done", 256'(ndone), 256'h0);
        launch(B_ABC, 1'b1);
        wait_done(1, lat, vbad);
        check("midrst_rerun_latency", 256'(lat), 256'(LAT));
        check("midrst_rerun_digest", data_out, ABC);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
